// File: rtl/tdc_scan_pkg.sv
// Shared types and width helpers for the debug scan-chain sequencer.
package tdc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_DONE
    } state_t;

    // Select width never collapses to zero, even for a single DR.
    function automatic int sel_width(input int num_dr);
        return (num_dr > 1) ? $clog2(num_dr) : 1;
    endfunction

    function automatic int cnt_width(input int dr_length);
        return $clog2(dr_length + 1);
    endfunction

endpackage

// File: rtl/tdc_scan_shifter.sv
// Host-side shift pair: tx feeds the DR serial input LSB first, rx collects the
// selected DR serial output into its MSB.
module tdc_scan_shifter
    import tdc_scan_pkg::*;
#(
    parameter int DR_LENGTH = 16,
    parameter int NUM_DR    = 4,
    parameter int SEL_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DR_LENGTH-1:0] wdata,
    input  logic                 shift_en,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM_DR-1:0]    serial_out,
    output logic                 tx_lsb,
    output logic [DR_LENGTH-1:0] rx
);
    logic [DR_LENGTH-1:0] tx_reg;
    logic [DR_LENGTH-1:0] rx_reg;
    logic [NUM_DR-1:0]    hit;
    logic                 serial_bit;

    generate
        for (genvar gi = 0; gi < NUM_DR; gi++) begin : g_mux
            assign hit[gi] = (sel == SEL_W'(gi)) && serial_out[gi];
        end
    endgenerate

    assign serial_bit = |hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg <= '0;
            rx_reg <= '0;
        end else if (load) begin
            tx_reg <= wdata;
        end else if (shift_en) begin
            tx_reg <= tx_reg >> 1;
            rx_reg <= {serial_bit, rx_reg[DR_LENGTH-1:1]};
        end
    end

    assign tx_lsb = tx_reg[0];
    assign rx     = rx_reg;

endmodule

// File: rtl/tdc_scan_seq.sv
// Debug scan-chain sequencer: accepts one host access at a time and walks the
// selected data register through capture, shift and, for writes, update.
module tdc_scan_seq
    import tdc_scan_pkg::*;
#(
    parameter int  DR_LENGTH = 16,
    parameter int  NUM_DR    = 4,
    localparam int SEL_W     = sel_width(NUM_DR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [SEL_W-1:0]     req_sel,
    input  logic [DR_LENGTH-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DR_LENGTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [NUM_DR-1:0]    dr_sel,
    output logic                 dr_capture,
    output logic                 dr_shift,
    output logic                 dr_update,
    output logic                 dr_serial_in,
    input  logic [NUM_DR-1:0]    dr_serial_out
);
    localparam int               CNT_W    = cnt_width(DR_LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_LENGTH - 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [SEL_W-1:0]     sel_reg;
    logic                 write_reg;
    logic                 err_reg;
    logic [DR_LENGTH-1:0] rsp_rdata_reg;
    logic                 accept;
    logic                 sel_oob;
    logic                 dr_active;
    logic                 tx_lsb;
    logic [DR_LENGTH-1:0] rx;

    assign sel_oob   = (32'(req_sel) >= 32'(NUM_DR));
    assign accept    = req_valid && req_ready;
    assign dr_active = (state_reg == ST_CAPTURE) || (state_reg == ST_SHIFT) ||
                       (state_reg == ST_UPDATE);

    generate
        for (genvar gi = 0; gi < NUM_DR; gi++) begin : g_dr_sel
            assign dr_sel[gi] = dr_active && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    tdc_scan_shifter #(
        .DR_LENGTH (DR_LENGTH),
        .NUM_DR    (NUM_DR),
        .SEL_W     (SEL_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .wdata      (req_wdata),
        .shift_en   (state_reg == ST_SHIFT),
        .sel        (sel_reg),
        .serial_out (dr_serial_out),
        .tx_lsb     (tx_lsb),
        .rx         (rx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            sel_reg       <= '0;
            write_reg     <= 1'b0;
            err_reg       <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                sel_reg   <= req_sel;
                write_reg <= req_write;
                err_reg   <= sel_oob;
            end
            if (state_reg == ST_DONE) begin
                rsp_rdata_reg <= rx;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        dr_capture   = 1'b0;
        dr_shift     = 1'b0;
        dr_update    = 1'b0;
        dr_serial_in = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = sel_oob ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                dr_capture = 1'b1;
                cnt_next   = '0;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                dr_shift     = 1'b1;
                // Reads shift zeros in; the DR is never updated, so its content is preserved.
                dr_serial_in = write_reg && tx_lsb;
                if (cnt_reg == CNT_LAST) begin
                    state_next = write_reg ? ST_UPDATE : ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_UPDATE: begin
                dr_update  = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid  = 1'b1;
                rsp_err    = err_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // rx is live only during DONE; the held copy covers the following access.
    assign rsp_rdata = (state_reg == ST_DONE) ? rx : rsp_rdata_reg;

endmodule

// File: tb/tb_tdc_scan_seq.sv
// Scoreboard bench for tdc_scan_seq with behavioural data registers.
module tb_tdc_scan_seq;
    localparam int DRL = 16;
    localparam int NDR = 4;

    typedef struct {
        logic        write;
        logic [15:0] rdata;
        int          lat;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            req_valid, req_ready, req_write;
    logic [1:0]      req_sel;
    logic [DRL-1:0]  req_wdata, rsp_rdata;
    logic            rsp_valid, rsp_err;
    logic [NDR-1:0]  dr_sel, dr_serial_out;
    logic            dr_capture, dr_shift, dr_update, dr_serial_in;

    // Second instance with a non-power-of-two DR count so out-of-range selects exist.
    logic            req_valid2, req_ready2, req_write2;
    logic [2:0]      req_sel2;
    logic [DRL-1:0]  req_wdata2, rsp_rdata2;
    logic            rsp_valid2, rsp_err2;
    logic [4:0]      dr_sel2, dr_serial_out2;
    logic            dr_capture2, dr_shift2, dr_update2, dr_serial_in2;

    tdc_scan_seq #(.DR_LENGTH(DRL), .NUM_DR(NDR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_sel(req_sel), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dr_sel(dr_sel), .dr_capture(dr_capture), .dr_shift(dr_shift),
        .dr_update(dr_update), .dr_serial_in(dr_serial_in), .dr_serial_out(dr_serial_out)
    );

    tdc_scan_seq #(.DR_LENGTH(DRL), .NUM_DR(5)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write2), .req_sel(req_sel2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .dr_sel(dr_sel2), .dr_capture(dr_capture2), .dr_shift(dr_shift2),
        .dr_update(dr_update2), .dr_serial_in(dr_serial_in2), .dr_serial_out(dr_serial_out2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural DRs: capture loads the shift stage, shift moves toward the LSB.
    logic [DRL-1:0] dr_shreg [NDR];
    logic [DRL-1:0] dr_par   [NDR];
    logic [DRL-1:0] exp_par  [NDR];
    logic           pl_en;
    logic [1:0]     pl_idx;
    logic [DRL-1:0] pl_val;

    always_comb begin
        dr_serial_out = '0;
        for (int i = 0; i < NDR; i++) dr_serial_out[i] = dr_shreg[i][0];
    end

    always @(posedge clk) begin
        if (pl_en) begin
            dr_par[pl_idx]   <= pl_val;
            dr_shreg[pl_idx] <= '0;
        end
        for (int i = 0; i < NDR; i++) begin
            if (dr_sel[i] === 1'b1) begin
                if (dr_capture)     dr_shreg[i] <= dr_par[i];
                else if (dr_shift)  dr_shreg[i] <= {dr_serial_in, dr_shreg[i][DRL-1:1]};
                else if (dr_update) dr_par[i]   <= dr_shreg[i];
            end
        end
    end

    // Scoreboard monitor
    exp_t sb[$];
    int   n_neg = 0, n0 = 0, viol = 0, cnt_cap = 0, cnt_shf = 0, cnt_upd = 0;
    bit   busy = 0, cur_write = 0;

    always @(negedge clk) begin
        exp_t e;
        n_neg++;
        if (rst) begin
            busy = 0; viol = 0; cnt_cap = 0; cnt_shf = 0; cnt_upd = 0;
        end else begin
            if (busy && req_ready) viol++;
            if (int'(dr_capture) + int'(dr_shift) + int'(dr_update) > 1) viol++;
            if (dr_capture || dr_shift || dr_update) begin
                if (!$onehot(dr_sel)) viol++;
            end else if (dr_sel != '0) viol++;
            if (dr_serial_in && !(dr_shift && cur_write)) viol++;
            if (dr_capture) cnt_cap++;
            if (dr_shift)   cnt_shf++;
            if (dr_update)  cnt_upd++;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] rsp %s: lat=%0d err=%0b rdata=0x%04h shifts=%0d updates=%0d",
                             e.tag, n_neg - n0, rsp_err, rsp_rdata, cnt_shf, cnt_upd);
                    check_eq({e.tag, "_lat"},     32'(n_neg - n0), 32'(e.lat));
                    check_eq({e.tag, "_err"},     32'(rsp_err), 32'd0);
                    check_eq({e.tag, "_rdata"},   32'(rsp_rdata), 32'(e.rdata));
                    check_eq({e.tag, "_capture"}, 32'(cnt_cap), 32'd1);
                    check_eq({e.tag, "_shifts"},  32'(cnt_shf), 32'(DRL));
                    check_eq({e.tag, "_updates"}, 32'(cnt_upd), e.write ? 32'd1 : 32'd0);
                    check_eq({e.tag, "_rules"},   32'(viol), 32'd0);
                end
                busy = 0; viol = 0; cnt_cap = 0; cnt_shf = 0; cnt_upd = 0;
            end
            if (req_valid && req_ready) begin
                busy = 1; n0 = n_neg; cur_write = req_write;
            end
        end
    end

    task automatic preload(input logic [1:0] idx, input logic [DRL-1:0] val);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
        exp_par[idx] = val;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        check_eq("accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        check_eq("rsp_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic push_exp(input logic w, input logic [1:0] s, input string tag);
        exp_t e;
        e.write = w; e.rdata = exp_par[s]; e.lat = w ? DRL + 3 : DRL + 2; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic w, input logic [1:0] s, input logic [DRL-1:0] wd,
                          input string tag);
        push_exp(w, s, tag);
        if (w) exp_par[s] = wd;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_sel = s; req_wdata = wd;
        wait_accept();
        req_valid = 1'b0;
        wait_idle();
        check_eq({tag, "_dr_par"}, 32'(dr_par[s]), 32'(exp_par[s]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;
        rst = 1'b1; req_valid = 0; req_write = 0; req_sel = 0; req_wdata = 0;
        req_valid2 = 0; req_write2 = 0; req_sel2 = 0; req_wdata2 = 0; dr_serial_out2 = '0;
        pl_en = 0; pl_idx = 0; pl_val = 0;
        preload(2'd0, 16'h0F0F);
        preload(2'd1, 16'hBEEF);
        preload(2'd2, 16'h1234);
        preload(2'd3, 16'h5A5A);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_ctrl", 32'({req_ready, rsp_valid, rsp_err, dr_capture, dr_shift,
                                    dr_update, dr_serial_in}), 32'b1000000);
        check_eq("reset_dr_sel", 32'(dr_sel), 32'd0);
        check_eq("reset_rdata",  32'(rsp_rdata), 32'd0);
        $display("[TB] reset released: ready=%0b dr_sel=%b", req_ready, dr_sel);

        run_op(1'b1, 2'd2, 16'hA5C3, "wr_dr2");
        repeat (3) @(negedge clk);
        check_eq("rdata_hold", 32'(rsp_rdata), 32'h1234);
        run_op(1'b0, 2'd1, 16'h0000, "rd_dr1");
        run_op(1'b0, 2'd2, 16'hFFFF, "rd_dr2");
        run_op(1'b1, 2'd0, 16'hFFFF, "wr_dr0");
        run_op(1'b1, 2'd3, 16'h0001, "wr_dr3");
        for (int k = 0; k < 6; k++) begin
            run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   16'($urandom), $sformatf("rand%0d", k));
        end

        // Held request with a wandering select: only the value at acceptance counts.
        push_exp(1'b0, 2'd0, "b2b_first");
        push_exp(1'b0, 2'd1, "b2b_second");
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_sel = 2'd0; req_wdata = 16'h0;
        wait_accept();
        for (int k = 0; k < 8; k++) begin
            req_sel = 2'($urandom); req_wdata = 16'($urandom); req_write = 1'($urandom);
            @(posedge clk); #1;
        end
        req_sel = 2'd1; req_write = 1'b0;
        wait_accept();
        req_valid = 1'b0;
        wait_idle();

        // Reset during the fifth shift cycle of a read.
        push_exp(1'b0, 2'd3, "abort");
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_sel = 2'd3;
        wait_accept();
        req_valid = 1'b0;
        for (int i = 0; i < 40 && cnt_shf != 5; i++) begin
            @(negedge clk); #1;
        end
        check_eq("abort_shift_cnt", 32'(cnt_shf), 32'd5);
        rst = 1'b1;
        @(negedge clk); #1;
        check_eq("abort_ctrl", 32'({req_ready, rsp_valid, rsp_err, dr_capture, dr_shift,
                                    dr_update, dr_serial_in}), 32'b1000000);
        check_eq("abort_dr_sel", 32'(dr_sel), 32'd0);
        check_eq("abort_rdata",  32'(rsp_rdata), 32'd0);
        rst = 1'b0;
        sb.delete();
        $display("[TB] abort: reset applied in shift cycle 5");
        repeat (25) @(negedge clk);
        run_op(1'b0, 2'd3, 16'h0, "rd_after_abort");

        // Out-of-range select on the five-DR instance.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            req_valid2 = 1'b1; req_sel2 = (k == 0) ? 3'd5 : 3'd7;
            @(posedge clk); #1;
            req_valid2 = 1'b0;
            @(negedge clk);
            check_eq($sformatf("oob%0d_rsp", k), 32'({rsp_valid2, rsp_err2}), 32'b11);
            check_eq($sformatf("oob%0d_strobes", k),
                     32'({dr_sel2, dr_capture2, dr_shift2, dr_update2, dr_serial_in2}), 32'd0);
            @(negedge clk);
            check_eq($sformatf("oob%0d_idle", k), 32'({req_ready2, rsp_valid2}), 32'b10);
            $display("[TB] oob sel=%0d: err response in cycle T+1", req_sel2);
        end

        // Highest legal select on the same instance must run normally.
        @(posedge clk); #1;
        req_valid2 = 1'b1; req_sel2 = 3'd4;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        n = 0; got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check_eq("sel4_capture", 32'({dr_capture2, rsp_valid2}), 32'b10);
                check_eq("sel4_dr_sel",  32'(dr_sel2), 32'b10000);
            end
            if (rsp_valid2) begin got = 1; n = i; end
        end
        check_eq("sel4_lat", 32'(n), 32'(DRL + 2));
        check_eq("sel4_err", 32'(rsp_err2), 32'd0);
        $display("[TB] sel=4 on five-DR instance: lat=%0d err=%0b", n, rsp_err2);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
